// File: rtl/sum_accumulator.sv
// sum_accumulator: collects CNT adder sums into a block total, then holds that
// total on a valid/ready output until the consumer takes it.
module sum_accumulator #(
  parameter int IN_W  = 5,
  parameter int CNT   = 8,
  parameter int ACC_W = IN_W + $clog2(CNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [7:0]       blk_count
);

  typedef enum logic {ACCUM, HOLD} state_t;

  // The last sample of a block is the one that arrives with this count.
  localparam logic [7:0] LAST_IDX = 8'(CNT - 1);

  state_t           state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [7:0]       samp_cnt_reg;
  logic             out_valid_reg;
  logic [ACC_W-1:0] out_total_reg;
  logic [7:0]       blk_count_reg;
  logic [ACC_W-1:0] acc_next;

  // Running sum including the sample on the input this cycle.
  assign acc_next = acc_reg + ACC_W'(in_sum);

  // in_ready is a pure decode of registered state: no path from in_valid/out_ready.
  assign in_ready  = (state_reg == ACCUM);
  assign out_valid = out_valid_reg;
  assign out_total = out_total_reg;
  assign blk_count = blk_count_reg;

  // Block accumulation / hold state machine; clear flushes without touching out_total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ACCUM;
      acc_reg       <= '0;
      samp_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_total_reg <= '0;
      blk_count_reg <= '0;
    end else if (clear) begin
      state_reg     <= ACCUM;
      acc_reg       <= '0;
      samp_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (in_valid) begin
            if (samp_cnt_reg == LAST_IDX) begin
              out_total_reg <= acc_next;
              out_valid_reg <= 1'b1;
              acc_reg       <= '0;
              samp_cnt_reg  <= '0;
              state_reg     <= HOLD;
            end else begin
              acc_reg      <= acc_next;
              samp_cnt_reg <= samp_cnt_reg + 8'd1;
            end
          end
        end
        HOLD: begin
          // Samples offered here are ignored; only the output handshake moves us on.
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            blk_count_reg <= blk_count_reg + 8'd1;
            state_reg     <= ACCUM;
          end
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

endmodule
